// File: rtl/pim_result_accumulator.sv
// -----------------------------------------------------------------------------
// pim_result_accumulator
//
// Sums K_TILES consecutive partial-product tiles from the PIM compute unit,
// adding them element by element, into one completed output tile. The
// completed tile sits in a one-entry output buffer that the result writer
// drains with a valid/ready handshake. The compute unit cannot be stalled.
// If a tile completes while the buffer is still occupied, that tile is
// dropped and the sticky overflow flag is set.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   in_valid    partial tile valid (compute unit result_valid)
//   in_tile     partial tile, PIM_MATRIX_SIZE x PIM_MATRIX_SIZE x ELEM_WIDTH
//   clear       abort the current partial accumulation
//   out_valid   completed tile available
//   out_ready   downstream accepts the tile
//   out_tile    completed tile
//   k_count     partials accumulated in the current group
//   overflow    sticky: a completed tile was dropped because the buffer was full
//   tiles_done  count of tiles handed off (out_valid && out_ready), wraps
// -----------------------------------------------------------------------------
module pim_result_accumulator #(
  parameter  int ELEM_WIDTH      = 32,
  parameter  int PIM_MATRIX_SIZE = 8,
  parameter  int K_TILES         = 4,
  parameter  int CNT_WIDTH       = 16,
  localparam int KW              = $clog2(K_TILES + 1)
) (
  input  logic                                                     clk,
  input  logic                                                     rst,
  input  logic                                                     in_valid,
  input  logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] in_tile,
  input  logic                                                     clear,
  output logic                                                     out_valid,
  input  logic                                                     out_ready,
  output logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] out_tile,
  output logic [KW-1:0]                                            k_count,
  output logic                                                     overflow,
  output logic [CNT_WIDTH-1:0]                                     tiles_done
);

  typedef logic [PIM_MATRIX_SIZE-1:0][PIM_MATRIX_SIZE-1:0][ELEM_WIDTH-1:0] tile_t;

  tile_t                acc_q, acc_d;
  tile_t                out_tile_q, out_tile_d;
  tile_t                sum;
  logic [KW-1:0]        k_q, k_d, k_base;
  logic                 out_valid_q, out_valid_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] tiles_done_q, tiles_done_d;
  logic                 start_new, complete, handshake, buf_free;

  // Element-wise sum, modulo 2^ELEM_WIDTH. A new group (empty accumulator,
  // or clear arriving with the tile) takes in_tile as is, so the stale
  // acc contents never leak into it.
  always_comb begin
    sum = '0;
    for (int i = 0; i < PIM_MATRIX_SIZE; i++) begin
      for (int j = 0; j < PIM_MATRIX_SIZE; j++) begin
        sum[i][j] = start_new ? in_tile[i][j] : acc_q[i][j] + in_tile[i][j];
      end
    end
  end

  always_comb begin
    k_base       = clear ? '0 : k_q;
    start_new    = (k_base == '0);
    complete     = in_valid && (k_base == KW'(K_TILES - 1));
    handshake    = out_valid_q && out_ready;
    buf_free     = !out_valid_q || out_ready;

    acc_d        = acc_q;
    k_d          = k_base;
    out_tile_d   = out_tile_q;
    out_valid_d  = out_valid_q;
    overflow_d   = overflow_q;
    tiles_done_d = tiles_done_q + CNT_WIDTH'(handshake);

    if (in_valid) begin
      acc_d = sum;
      k_d   = complete ? '0 : k_base + KW'(1);
    end

    // A completion landing on a free buffer reloads it, and that covers the
    // case where the old tile hands off in the same cycle: out_valid stays high.
    if (complete && buf_free) begin
      out_tile_d  = sum;
      out_valid_d = 1'b1;
    end else if (handshake) begin
      out_valid_d = 1'b0;
    end

    if (complete && !buf_free) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      out_tile_q   <= '0;
      k_q          <= '0;
      out_valid_q  <= 1'b0;
      overflow_q   <= 1'b0;
      tiles_done_q <= '0;
    end else begin
      acc_q        <= acc_d;
      out_tile_q   <= out_tile_d;
      k_q          <= k_d;
      out_valid_q  <= out_valid_d;
      overflow_q   <= overflow_d;
      tiles_done_q <= tiles_done_d;
    end
  end

  assign out_tile   = out_tile_q;
  assign out_valid  = out_valid_q;
  assign k_count    = k_q;
  assign overflow   = overflow_q;
  assign tiles_done = tiles_done_q;

endmodule

// File: tb/tb_pim_result_accumulator.sv
module tb_pim_result_accumulator;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int K  = 4;
  localparam int CW = 16;
  localparam int KW = $clog2(K + 1);

  typedef logic [N-1:0][N-1:0][W-1:0] tile_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  tile_t          in_tile;
  logic           clear;
  logic           out_valid;
  logic           out_ready;
  tile_t          out_tile;
  logic [KW-1:0]  k_count;
  logic           overflow;
  logic [CW-1:0]  tiles_done;

  pim_result_accumulator #(
    .ELEM_WIDTH(W), .PIM_MATRIX_SIZE(N), .K_TILES(K), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_tile(in_tile),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_tile(out_tile), .k_count(k_count), .overflow(overflow),
    .tiles_done(tiles_done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_tile(input string name, input tile_t act, input tile_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (act[i][j] !== exp[i][j]) begin
            $display("FAIL %s: element [%0d][%0d] got 0x%08h, expected 0x%08h (t=%0t)",
                     name, i, j, act[i][j], exp[i][j], $time);
            return;
          end
    end
  endtask

  function automatic tile_t fill(input logic [W-1:0] v);
    tile_t t;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        t[i][j] = v;
    return t;
  endfunction

  // One row = inputs for one clock edge and the outputs expected after it.
  typedef struct {
    bit          rst;
    bit          iv;
    logic [W-1:0] val;
    bit          clr;
    bit          rdy;
    bit          e_ov;
    logic [W-1:0] e_tile;
    int          e_k;
    bit          e_of;
    int          e_done;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit iv, input logic [W-1:0] val, input bit clr,
                     input bit rdy, input bit eov, input logic [W-1:0] et, input int ek,
                     input bit eof, input int ed);
    vec_t v;
    v.rst = r; v.iv = iv; v.val = val; v.clr = clr; v.rdy = rdy;
    v.e_ov = eov; v.e_tile = et; v.e_k = ek; v.e_of = eof; v.e_done = ed;
    tbl.push_back(v);
  endtask

  // Reference model: the group is a list of partial tiles; its sum is taken
  // when the list reaches K entries.
  tile_t         grp[$];
  tile_t         m_tile;
  bit            m_valid, m_ovf;
  logic [CW-1:0] m_done;

  task automatic model_step(input bit r, input bit iv, input tile_t t, input bit clr, input bit rdy);
    tile_t s;
    bit loaded, hs, free;
    if (r) begin
      grp.delete(); m_tile = '0; m_valid = 0; m_ovf = 0; m_done = '0;
      return;
    end
    if (clr) grp.delete();
    hs = m_valid && rdy;
    free = !m_valid || rdy;
    loaded = 0;
    if (iv) begin
      grp.push_back(t);
      if (grp.size() == K) begin
        s = '0;
        foreach (grp[g])
          for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
              s[i][j] = s[i][j] + grp[g][i][j];
        grp.delete();
        if (free) begin m_tile = s; m_valid = 1; loaded = 1; end
        else m_ovf = 1;
      end
    end
    if (hs) begin
      m_done = m_done + 1'b1;
      if (!loaded) m_valid = 0;
    end
  endtask

  initial begin
    tile_t t;
    rst = 1'b0; in_valid = 1'b0; in_tile = '0; clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    //   rst iv val         clr rdy   ov tile        k of done
    add(1, 0, 0,          0, 0,     0, 0,          0, 0, 0);
    // Basic sum 1+2+3+4
    add(0, 1, 1,          0, 1,     0, 0,          1, 0, 0);
    add(0, 1, 2,          0, 1,     0, 0,          2, 0, 0);
    add(0, 1, 3,          0, 1,     0, 0,          3, 0, 0);
    add(0, 1, 4,          0, 1,     1, 10,         0, 0, 0);
    add(0, 0, 0,          0, 1,     0, 10,         0, 0, 1);
    // Modulo wrap
    add(0, 1, 32'hFFFF_FFFF, 0, 1,  0, 10,         1, 0, 1);
    add(0, 1, 2,          0, 1,     0, 10,         2, 0, 1);
    add(0, 1, 0,          0, 1,     0, 10,         3, 0, 1);
    add(0, 1, 0,          0, 1,     1, 1,          0, 0, 1);
    add(0, 0, 0,          0, 1,     0, 1,          0, 0, 2);
    // Buffer full: second group dropped
    add(0, 1, 1,          0, 0,     0, 1,          1, 0, 2);
    add(0, 1, 1,          0, 0,     0, 1,          2, 0, 2);
    add(0, 1, 1,          0, 0,     0, 1,          3, 0, 2);
    add(0, 1, 1,          0, 0,     1, 4,          0, 0, 2);
    add(0, 1, 5,          0, 0,     1, 4,          1, 0, 2);
    add(0, 1, 5,          0, 0,     1, 4,          2, 0, 2);
    add(0, 1, 5,          0, 0,     1, 4,          3, 0, 2);
    add(0, 1, 5,          0, 0,     1, 4,          0, 1, 2);
    add(0, 0, 0,          0, 1,     0, 4,          0, 1, 3);
    // Completion in the same cycle as a handshake
    add(0, 1, 1,          0, 0,     0, 4,          1, 1, 3);
    add(0, 1, 1,          0, 0,     0, 4,          2, 1, 3);
    add(0, 1, 1,          0, 0,     0, 4,          3, 1, 3);
    add(0, 1, 1,          0, 0,     1, 4,          0, 1, 3);
    add(0, 1, 2,          0, 0,     1, 4,          1, 1, 3);
    add(0, 1, 2,          0, 0,     1, 4,          2, 1, 3);
    add(0, 1, 2,          0, 0,     1, 4,          3, 1, 3);
    add(0, 1, 2,          0, 1,     1, 8,          0, 1, 4);
    add(0, 0, 0,          0, 0,     1, 8,          0, 1, 4);
    add(0, 0, 0,          0, 1,     0, 8,          0, 1, 5);
    // clear together with in_valid starts a new group
    add(0, 1, 7,          0, 1,     0, 8,          1, 1, 5);
    add(0, 1, 7,          0, 1,     0, 8,          2, 1, 5);
    add(0, 1, 3,          1, 1,     0, 8,          1, 1, 5);
    add(0, 1, 1,          0, 1,     0, 8,          2, 1, 5);
    add(0, 1, 1,          0, 1,     0, 8,          3, 1, 5);
    add(0, 1, 1,          0, 1,     1, 6,          0, 1, 5);
    add(0, 0, 0,          0, 0,     1, 6,          0, 1, 5);
    // Reset mid-group with a buffered tile
    add(0, 1, 9,          0, 0,     1, 6,          1, 1, 5);
    add(0, 1, 9,          0, 0,     1, 6,          2, 1, 5);
    add(0, 1, 9,          0, 0,     1, 6,          3, 1, 5);
    add(1, 0, 0,          0, 0,     0, 0,          0, 0, 0);
    add(0, 1, 2,          0, 0,     0, 0,          1, 0, 0);
    add(0, 1, 2,          0, 0,     0, 0,          2, 0, 0);
    add(0, 1, 2,          0, 0,     0, 0,          3, 0, 0);
    add(0, 1, 2,          0, 0,     1, 8,          0, 0, 0);
    add(0, 0, 0,          0, 1,     0, 8,          0, 0, 1);
    // clear on its own discards the partial
    add(0, 1, 5,          0, 1,     0, 8,          1, 0, 1);
    add(0, 0, 0,          1, 1,     0, 8,          0, 0, 1);
    add(0, 1, 3,          0, 1,     0, 8,          1, 0, 1);
    add(0, 1, 3,          0, 1,     0, 8,          2, 0, 1);
    add(0, 1, 3,          0, 1,     0, 8,          3, 0, 1);
    add(0, 1, 3,          0, 1,     1, 12,         0, 0, 1);
    add(0, 0, 0,          0, 1,     0, 12,         0, 0, 2);

    for (int r = 0; r < tbl.size(); r++) begin
      rst = tbl[r].rst; in_valid = tbl[r].iv; in_tile = fill(tbl[r].val);
      clear = tbl[r].clr; out_ready = tbl[r].rdy;
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", r), out_valid, tbl[r].e_ov);
      chk_tile($sformatf("row%0d out_tile", r), out_tile, fill(tbl[r].e_tile));
      chk($sformatf("row%0d k_count", r), k_count, tbl[r].e_k);
      chk($sformatf("row%0d overflow", r), overflow, tbl[r].e_of);
      chk($sformatf("row%0d tiles_done", r), tiles_done, tbl[r].e_done);
    end

    // Randomized phase against the reference model
    model_step(1, 0, '0, 0, 0);
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          case ($urandom_range(3))
            0:       t[i][j] = 32'hFFFF_FFFF;
            1:       t[i][j] = $urandom_range(15);
            default: t[i][j] = $urandom;
          endcase
      rst       = ($urandom_range(199) == 0);
      in_valid  = ($urandom_range(9) < 7);
      clear     = ($urandom_range(19) == 0);
      out_ready = ($urandom_range(1) == 1);
      in_tile   = t;
      model_step(rst, in_valid, t, clear, out_ready);
      @(posedge clk); #1;
      chk("rnd out_valid", out_valid, m_valid);
      chk_tile("rnd out_tile", out_tile, m_tile);
      chk("rnd k_count", k_count, grp.size());
      chk("rnd overflow", overflow, m_ovf);
      chk("rnd tiles_done", tiles_done, m_done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
